phaser_multi: RTL



---
 rtl/phaser_pkg.sv | 23 ++
 rtl/phaser_chan.sv | 145 ++++++++++++++
 rtl/phaser_multi.sv | 59 +++++
 3 files changed

// File: rtl/phaser_pkg.sv
// Shared definitions for the DCM/MMCM dynamic phase-shift controller.
package phaser_pkg;

  // Per-channel stepper state codes (visible on dps_sm_vec).
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_TMB = 3'd1,
    WAIT_DCM = 3'd2,
    INIT_DPS = 3'd3,
    INC_DEC  = 3'd4,
    WAIT_DPS = 3'd5,
    UNFIRE   = 3'd6
  } dps_state_e;

  // Phase counter width per device family.
  localparam int unsigned MXPHASE_VIRTEX2 = 6;
  localparam int unsigned MXPHASE_VIRTEX6 = 11;

  // current_phase value after reset per device family.
  localparam int unsigned PHASE_OFFSET_VIRTEX2 = 32;
  localparam int unsigned PHASE_OFFSET_VIRTEX6 = 0;

endpackage

// File: rtl/phaser_chan.sv
// One phase-shift channel: stepper FSM, frozen target, tracked phase,
// psdone watchdog and the registered DCM/VME-facing outputs.
module phaser_chan
  import phaser_pkg::*;
#(
  parameter int unsigned MXPHASE      = MXPHASE_VIRTEX6,
  parameter int unsigned PHASE_OFFSET = PHASE_OFFSET_VIRTEX6,
  parameter int unsigned MXTO         = 8,
  parameter int unsigned PS_TIMEOUT   = 200
) (
  input  logic               clock,
  input  logic               global_reset,
  input  logic               chan_reset,
  input  logic               lock_tmb,
  input  logic               lock_dcm,
  input  logic               psdone,
  input  logic               fire,
  input  logic [MXPHASE-1:0] phase,
  input  logic               wrap_en,
  output logic               psen,
  output logic               psincdec,
  output logic               busy,
  output logic [2:0]         dps_sm_vec,
  output logic               update_quad,
  output logic [MXPHASE-1:0] current_phase,
  output logic               timeout_err
);

  localparam logic [MXPHASE-1:0] PHASE_RST = MXPHASE'(PHASE_OFFSET);
  localparam logic [MXPHASE-1:0] HALF      = MXPHASE'(1) << (MXPHASE - 1);
  localparam logic [MXTO-1:0]    WD_LAST   = MXTO'(PS_TIMEOUT - 1);

  logic rst;

  dps_state_e         state_q, state_d;
  logic [MXPHASE-1:0] target_q, target_d;
  logic [MXPHASE-1:0] cur_q, cur_d;
  logic [MXTO-1:0]    wd_q, wd_d;
  logic               terr_q, terr_d;
  logic               psen_q, psen_d;
  logic               psincdec_q, psincdec_d;
  logic               uq_q, uq_d;
  logic [2:0]         sm_q, sm_d;

  logic [MXPHASE-1:0] diff;
  logic               at_target;
  logic               step_inc;

  assign rst = global_reset | chan_reset;

  // Step direction from the frozen target and the pre-step phase.
  // In wrap mode the modular distance picks the shorter way round; an exact
  // half-circle tie steps upward.
  always_comb begin
    diff      = target_q - cur_q;
    at_target = (target_q == cur_q);
    step_inc  = wrap_en ? (diff <= HALF) : (target_q > cur_q);
  end

  // Next-state, datapath and registered-output terms.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    cur_d      = cur_q;
    wd_d       = wd_q;
    terr_d     = terr_q;
    psen_d     = (state_q == INC_DEC);
    psincdec_d = (state_q == INC_DEC) ? step_inc : psincdec_q;
    uq_d       = (state_q == WAIT_TMB);
    sm_d       = state_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          state_d  = WAIT_TMB;
          target_d = phase;
          terr_d   = 1'b0;
        end
      end
      WAIT_TMB: begin
        if (lock_tmb) state_d = WAIT_DCM;
      end
      WAIT_DCM: begin
        if (lock_dcm) state_d = at_target ? UNFIRE : INIT_DPS;
      end
      INIT_DPS: begin
        state_d = INC_DEC;
      end
      INC_DEC: begin
        state_d = WAIT_DPS;
        cur_d   = step_inc ? cur_q + 1'b1 : cur_q - 1'b1;
        wd_d    = '0;
      end
      WAIT_DPS: begin
        if (psdone) begin
          state_d = at_target ? UNFIRE : INC_DEC;
        end else if (wd_q == WD_LAST) begin
          terr_d  = 1'b1;
          state_d = UNFIRE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      UNFIRE: begin
        if (!fire) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Channel register bank with synchronous global/per-channel reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      cur_q      <= PHASE_RST;
      wd_q       <= '0;
      terr_q     <= 1'b0;
      psen_q     <= 1'b0;
      psincdec_q <= 1'b0;
      uq_q       <= 1'b0;
      sm_q       <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      cur_q      <= cur_d;
      wd_q       <= wd_d;
      terr_q     <= terr_d;
      psen_q     <= psen_d;
      psincdec_q <= psincdec_d;
      uq_q       <= uq_d;
      sm_q       <= sm_d;
    end
  end

  assign psen          = psen_q;
  assign psincdec      = psincdec_q;
  assign busy          = (state_q != IDLE);
  assign dps_sm_vec    = sm_q;
  assign update_quad   = uq_q;
  assign current_phase = cur_q;
  assign timeout_err   = terr_q;

endmodule

// File: rtl/phaser_multi.sv
// Multi-channel DCM/MMCM phase-shift controller: NCH independent steppers
// sharing the TMB lock, wrap mode and clock.
module phaser_multi
  import phaser_pkg::*;
#(
  parameter int unsigned NCH          = 4,
  parameter int unsigned MXPHASE      = MXPHASE_VIRTEX6,
  parameter int unsigned PHASE_OFFSET = PHASE_OFFSET_VIRTEX6,
  parameter int unsigned MXTO         = 8,
  parameter int unsigned PS_TIMEOUT   = 200
) (
  input  logic                   clock,
  input  logic                   global_reset,
  input  logic                   lock_tmb,
  input  logic [NCH-1:0]         lock_dcm,
  output logic [NCH-1:0]         psen,
  output logic [NCH-1:0]         psincdec,
  input  logic [NCH-1:0]         psdone,
  input  logic [NCH-1:0]         fire,
  input  logic [NCH-1:0]         reset,
  input  logic [NCH*MXPHASE-1:0] phase,
  input  logic                   wrap_en,
  output logic [NCH-1:0]         busy,
  output logic                   any_busy,
  output logic [3*NCH-1:0]       dps_sm_vec,
  output logic [NCH-1:0]         update_quad,
  output logic [NCH*MXPHASE-1:0] current_phase,
  output logic [NCH-1:0]         timeout_err
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    phaser_chan #(
      .MXPHASE      (MXPHASE),
      .PHASE_OFFSET (PHASE_OFFSET),
      .MXTO         (MXTO),
      .PS_TIMEOUT   (PS_TIMEOUT)
    ) u_chan (
      .clock         (clock),
      .global_reset  (global_reset),
      .chan_reset    (reset[i]),
      .lock_tmb      (lock_tmb),
      .lock_dcm      (lock_dcm[i]),
      .psdone        (psdone[i]),
      .fire          (fire[i]),
      .phase         (phase[i*MXPHASE +: MXPHASE]),
      .wrap_en       (wrap_en),
      .psen          (psen[i]),
      .psincdec      (psincdec[i]),
      .busy          (busy[i]),
      .dps_sm_vec    (dps_sm_vec[i*3 +: 3]),
      .update_quad   (update_quad[i]),
      .current_phase (current_phase[i*MXPHASE +: MXPHASE]),
      .timeout_err   (timeout_err[i])
    );
  end

  assign any_busy = |busy;

endmodule
